rram_swap_ctrl: RTL

RRAM_SWAP_CTRL -- requirements
Module: rram_swap_ctrl

---
 rtl/rram_swap_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rram_swap_ctrl.sv
// Double-buffered row RAM swap controller: sequences renderer fills against display row swaps.
// Optional saturating overrun counter is compiled in with RRAM_OVERRUN_CNT_EN.
module rram_swap_ctrl #(
   parameter int ROWS  = 240,
   parameter int ROW_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             frame_sync,
   input  logic             rram_swap,
   input  logic             fill_done,
   output logic             fill_start,
   output logic [ROW_W-1:0] fill_row,
   output logic             bank_sel,
   output logic             busy,
   output logic             overrun
`ifdef RRAM_OVERRUN_CNT_EN
   ,
   output logic [15:0]      overrun_count
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PREFILL   = 2'd1,
      WAIT_SWAP = 2'd2,
      FILLING   = 2'd3
   } state_t;

   state_t state;
   // A start requested while fill_start is already high is deferred by one cycle.
   logic   start_hold;

   function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] r);
      if (r == ROW_W'(ROWS - 1)) return '0;
      return r + ROW_W'(1);
   endfunction

`ifdef RRAM_OVERRUN_CNT_EN
   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      if (c == 16'hFFFF) return c;
      return c + 16'd1;
   endfunction
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         start_hold <= 1'b0;
         fill_start <= 1'b0;
         fill_row   <= '0;
         bank_sel   <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
`ifdef RRAM_OVERRUN_CNT_EN
         overrun_count <= '0;
`endif
      end else begin
         fill_start <= start_hold;
         start_hold <= 1'b0;
         overrun    <= 1'b0;
         if (!enable) begin
            state      <= IDLE;
            busy       <= 1'b0;
            fill_start <= 1'b0;
         end else if (frame_sync && state != IDLE) begin
            // Restart the frame from row 0 into the current back bank.
            state      <= PREFILL;
            busy       <= 1'b1;
            fill_row   <= '0;
            fill_start <= ~fill_start;
            start_hold <= fill_start;
         end else begin
            case (state)
               IDLE: begin
                  state      <= PREFILL;
                  busy       <= 1'b1;
                  fill_row   <= '0;
                  fill_start <= ~fill_start;
                  start_hold <= fill_start;
               end
               PREFILL: begin
                  if (fill_done) begin
                     state <= WAIT_SWAP;
                     busy  <= 1'b0;
                  end
               end
               WAIT_SWAP: begin
                  if (rram_swap) begin
                     state      <= FILLING;
                     busy       <= 1'b1;
                     bank_sel   <= ~bank_sel;
                     fill_row   <= next_row(fill_row);
                     fill_start <= ~fill_start;
                     start_hold <= fill_start;
                  end
               end
               FILLING: begin
                  if (rram_swap && fill_done) begin
                     bank_sel   <= ~bank_sel;
                     fill_row   <= next_row(fill_row);
                     fill_start <= ~fill_start;
                     start_hold <= fill_start;
                  end else if (rram_swap) begin
                     // Back bank not ready: keep showing the current bank.
                     overrun <= 1'b1;
`ifdef RRAM_OVERRUN_CNT_EN
                     overrun_count <= sat_inc(overrun_count);
`endif
                  end else if (fill_done) begin
                     state <= WAIT_SWAP;
                     busy  <= 1'b0;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
